// File: rtl/ysyx_lsu_pkg.sv
// ysyx_lsu_pkg: shared definitions for the load/store unit.
//   - lsu_state_e : FSM state encoding
//   - LSU_*       : funct3-style access size codes
//   - OKAY        : AXI response code for a successful transfer
package ysyx_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] OKAY = 2'b00;

  // Halfword codes (H/HU) share size[1:0]=01; any code with size[1]
  // set is handled as a full word.
  function automatic logic size_is_half(input logic [2:0] size);
    return size[1:0] == 2'b01;
  endfunction

  function automatic logic size_is_word(input logic [2:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// ysyx_lsu_align: purely combinational byte-lane steering for the LSU.
// Ports:
//   addr_lo    in  [1:0]        byte offset within the word
//   size       in  [2:0]        funct3 size code
//   store_data in  [BIT_W-1:0]  right-aligned store data
//   load_word  in  [BIT_W-1:0]  word returned by the bus
//   wstrb      out [BIT_W/8-1:0] byte strobes for the store
//   wdata      out [BIT_W-1:0]  store data moved into its byte lanes
//   load_data  out [BIT_W-1:0]  extracted and sign/zero-extended load value
//   misalign   out              access crosses its natural alignment
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
#(
  parameter int BIT_W = 32
) (
  input  logic [1:0]         addr_lo,
  input  logic [2:0]         size,
  input  logic [BIT_W-1:0]   store_data,
  input  logic [BIT_W-1:0]   load_word,
  output logic [BIT_W/8-1:0] wstrb,
  output logic [BIT_W-1:0]   wdata,
  output logic [BIT_W-1:0]   load_data,
  output logic               misalign
);

  localparam int SB = BIT_W / 8;

  logic [4:0]       shamt;
  logic [BIT_W-1:0] shifted;
  logic [SB-1:0]    base_strb;

  assign shamt = {addr_lo, 3'b000};

  always_comb begin
    shifted   = load_word >> shamt;
    base_strb = '1;
    load_data = shifted;
    case (size)
      LSU_B: begin
        base_strb = SB'(1);
        load_data = {{(BIT_W-8){shifted[7]}}, shifted[7:0]};
      end
      LSU_BU: begin
        base_strb = SB'(1);
        load_data = {{(BIT_W-8){1'b0}}, shifted[7:0]};
      end
      LSU_H: begin
        base_strb = SB'(3);
        load_data = {{(BIT_W-16){shifted[15]}}, shifted[15:0]};
      end
      LSU_HU: begin
        base_strb = SB'(3);
        load_data = {{(BIT_W-16){1'b0}}, shifted[15:0]};
      end
      default: begin
        base_strb = '1;
        load_data = shifted;
      end
    endcase
    wstrb    = base_strb << addr_lo;
    wdata    = store_data << shamt;
    misalign = (size_is_half(size) && addr_lo[0]) ||
               (size_is_word(size) && (addr_lo != 2'b00));
  end

endmodule

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: load/store unit between EXU and an AXI4-Lite bus.
// Takes one request at a time from EXU, runs a single AXI4-Lite read or
// write, and returns a one-cycle done pulse with an error flag.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   exu_avalid/ren/wen/addr/wdata/size   request from EXU (held until done)
//   exu_rdata_o, exu_rvalid_o, exu_wready_o, exu_err_o   completion to EXU
//   ar*/r*   AXI4-Lite read address / read data channels
//   aw*/w*/b* AXI4-Lite write address / write data / write response channels
// Handshake: a transfer on any AXI channel happens at the rising edge
// where both valid and ready are high; a raised valid, with its address,
// data and strobe, is held unchanged until that edge and dropped after it.
module ysyx_lsu
  import ysyx_lsu_pkg::*;
#(
  parameter int BIT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exu_avalid,
  input  logic               exu_ren,
  input  logic               exu_wen,
  input  logic [BIT_W-1:0]   exu_addr,
  input  logic [BIT_W-1:0]   exu_wdata,
  input  logic [2:0]         exu_size,
  output logic [BIT_W-1:0]   exu_rdata_o,
  output logic               exu_rvalid_o,
  output logic               exu_wready_o,
  output logic               exu_err_o,
  output logic [BIT_W-1:0]   araddr_o,
  output logic               arvalid_o,
  input  logic               arready,
  input  logic [BIT_W-1:0]   rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready_o,
  output logic [BIT_W-1:0]   awaddr_o,
  output logic               awvalid_o,
  input  logic               awready,
  output logic [BIT_W-1:0]   wdata_o,
  output logic [BIT_W/8-1:0] wstrb_o,
  output logic               wvalid_o,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready_o
);

  lsu_state_e state_q, state_d;

  logic [BIT_W-1:0]   addr_q;
  logic [2:0]         size_q;
  logic               is_load_q;
  logic [BIT_W-1:0]   wdata_q;
  logic [BIT_W/8-1:0] wstrb_q;
  logic               aw_done_q;
  logic               w_done_q;
  logic               err_q;
  logic [BIT_W-1:0]   rdata_q;

  logic               req_fire;
  logic [1:0]         al_addr_lo;
  logic [2:0]         al_size;
  logic [BIT_W/8-1:0] al_wstrb;
  logic [BIT_W-1:0]   al_wdata;
  logic [BIT_W-1:0]   al_load;
  logic               al_misalign;

  assign req_fire = exu_avalid && (exu_ren || exu_wen);

  // In IDLE the aligner looks at the live request (store formatting and
  // misalign detection at capture); afterwards it uses the latched request
  // so the returned word is extracted with the captured offset and size.
  assign al_addr_lo = (state_q == S_IDLE) ? exu_addr[1:0] : addr_q[1:0];
  assign al_size    = (state_q == S_IDLE) ? exu_size      : size_q;

  ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
    .addr_lo    (al_addr_lo),
    .size       (al_size),
    .store_data (exu_wdata),
    .load_word  (rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  // Both AXI address channels always carry the word-aligned address.
  assign araddr_o    = {addr_q[BIT_W-1:2], 2'b00};
  assign awaddr_o    = {addr_q[BIT_W-1:2], 2'b00};
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign exu_rdata_o = rdata_q;

  always_comb begin
    state_d      = state_q;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    awvalid_o    = 1'b0;
    wvalid_o     = 1'b0;
    bready_o     = 1'b0;
    exu_rvalid_o = 1'b0;
    exu_wready_o = 1'b0;
    exu_err_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          if (al_misalign)  state_d = S_DONE;
          else if (exu_ren) state_d = S_RD_ADDR;
          else              state_d = S_WR_REQ;
        end
      end
      S_RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid) state_d = S_DONE;
      end
      S_WR_REQ: begin
        // AW and W finish independently; leave once both have been taken,
        // counting a handshake happening on this very edge.
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        exu_rvalid_o = is_load_q;
        exu_wready_o = !is_load_q;
        exu_err_o    = err_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      is_load_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            addr_q    <= exu_addr;
            size_q    <= exu_size;
            is_load_q <= exu_ren;
            wdata_q   <= al_wdata;
            wstrb_q   <= al_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= al_misalign;
            // A rejected load still completes, with a zero result.
            if (al_misalign && exu_ren) rdata_q <= '0;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rdata_q <= al_load;
            err_q   <= (rresp != OKAY);
          end
        end
        S_WR_REQ: begin
          if (awvalid_o && awready) aw_done_q <= 1'b1;
          if (wvalid_o && wready)   w_done_q  <= 1'b1;
        end
        S_WR_RESP: begin
          if (bvalid) err_q <= (bresp != OKAY);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu: scoreboard bench for ysyx_lsu with a behavioural AXI4-Lite
// slave whose per-transaction wait states and responses are set by the driver.
module tb_ysyx_lsu;

  localparam int BIT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             exu_avalid = 0, exu_ren = 0, exu_wen = 0;
  logic [BIT_W-1:0] exu_addr = '0, exu_wdata = '0;
  logic [2:0]       exu_size = '0;
  logic [BIT_W-1:0] exu_rdata_o;
  logic             exu_rvalid_o, exu_wready_o, exu_err_o;
  logic [BIT_W-1:0] araddr_o;
  logic             arvalid_o, arready = 0;
  logic [BIT_W-1:0] rdata = '0;
  logic [1:0]       rresp = '0;
  logic             rvalid = 0, rready_o;
  logic [BIT_W-1:0] awaddr_o;
  logic             awvalid_o, awready = 0;
  logic [BIT_W-1:0] wdata_o;
  logic [3:0]       wstrb_o;
  logic             wvalid_o, wready = 0;
  logic [1:0]       bresp = '0;
  logic             bvalid = 0, bready_o;

  ysyx_lsu #(.BIT_W(BIT_W)) dut (
    .clk(clk), .rst(rst),
    .exu_avalid(exu_avalid), .exu_ren(exu_ren), .exu_wen(exu_wen),
    .exu_addr(exu_addr), .exu_wdata(exu_wdata), .exu_size(exu_size),
    .exu_rdata_o(exu_rdata_o), .exu_rvalid_o(exu_rvalid_o),
    .exu_wready_o(exu_wready_o), .exu_err_o(exu_err_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready(awready),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready_o(bready_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] size);
    case (size[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                             input logic [2:0] size);
    logic [31:0] sh;
    sh = word >> (8 * off);
    case (size)
      3'b000:  return (sh & 32'hFF)   | (sh[7]  ? 32'hFFFF_FF00 : 32'h0);
      3'b001:  return (sh & 32'hFFFF) | (sh[15] ? 32'hFFFF_0000 : 32'h0);
      3'b100:  return sh & 32'hFF;
      3'b101:  return sh & 32'hFFFF;
      default: return sh;
    endcase
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [BIT_W-1:0] exp_q[$];
  logic [1:0]       exp_kind_q[$];   // {rvalid, wready}
  logic             exp_err_q[$];
  logic             exp_bus_q[$];    // response handshake expected before done

  // ---------------- slave knobs (set by driver) ----------------
  int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
  logic [31:0] r_word;
  logic [1:0]  r_resp_k, b_resp_k;
  logic        exp_rd_bus = 0, exp_wr_bus = 0;
  logic [31:0] exp_baddr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] last_load = '0;

  // slave state
  int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic ar_up, ar_hs, r_hs, aw_up, aw_hs, w_up, w_hs, b_hs;

  // ---------------- AXI slave + bus monitor ----------------
  // At each falling edge the slave looks at the DUT's valids/readies and
  // sets its own; a handshake is recorded when both will be high at the
  // coming rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst || !(exp_rd_bus || exp_wr_bus)) begin
        if (rst && (arvalid_o || awvalid_o || wvalid_o)) flag_fail("unexpected_bus_valid");
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_up = 0; ar_hs = 0; r_hs = 0; aw_up = 0; aw_hs = 0; w_up = 0; w_hs = 0; b_hs = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rresp = 0; bresp = 0;
      end else if (exp_rd_bus) begin
        if (awvalid_o || wvalid_o) flag_fail("write_valid_during_load");
        // stray write response, must be ignored
        bvalid = ($urandom_range(3) == 0);
        bresp  = 2'($urandom_range(3));
        // R channel first so rvalid never precedes the AR handshake edge
        if (ar_hs && !r_hs) begin
          if (r_cnt >= r_wait) begin
            rvalid = 1; rdata = r_word; rresp = r_resp_k;
            if (rready_o) r_hs = 1;
          end else begin
            rvalid = 0; rdata = $urandom; r_cnt++;
          end
        end else begin
          rvalid = 0;
        end
        if (arvalid_o) begin
          check("araddr", araddr_o, exp_baddr);
          if (ar_hs) flag_fail("arvalid_after_handshake");
          else begin
            ar_up = 1;
            if (ar_cnt >= ar_wait) begin arready = 1; ar_hs = 1; end
            else begin arready = 0; ar_cnt++; end
          end
        end else begin
          arready = 0;
          if (ar_up && !ar_hs) flag_fail("arvalid_dropped");
        end
      end else begin
        if (arvalid_o) flag_fail("read_valid_during_store");
        // stray read data, must be ignored
        rvalid = ($urandom_range(3) == 0);
        rdata  = $urandom;
        rresp  = 2'($urandom_range(3));
        if (aw_hs && w_hs && !b_hs) begin
          if (b_cnt >= b_wait) begin
            bvalid = 1; bresp = b_resp_k;
            if (bready_o) b_hs = 1;
          end else begin
            bvalid = 0; b_cnt++;
          end
        end else begin
          bvalid = 0;
        end
        if (awvalid_o) begin
          check("awaddr", awaddr_o, exp_baddr);
          if (aw_hs) flag_fail("awvalid_after_handshake");
          else begin
            aw_up = 1;
            if (aw_cnt >= aw_wait) begin awready = 1; aw_hs = 1; end
            else begin awready = 0; aw_cnt++; end
          end
        end else begin
          awready = 0;
          if (aw_up && !aw_hs) flag_fail("awvalid_dropped");
        end
        if (wvalid_o) begin
          check("wdata", wdata_o, exp_wdata);
          check("wstrb", {28'h0, wstrb_o}, {28'h0, exp_wstrb});
          if (w_hs) flag_fail("wvalid_after_handshake");
          else begin
            w_up = 1;
            if (w_cnt >= w_wait) begin wready = 1; w_hs = 1; end
            else begin wready = 0; w_cnt++; end
          end
        end else begin
          wready = 0;
          if (w_up && !w_hs) flag_fail("wvalid_dropped");
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    logic [31:0] e_val;
    logic [1:0]  e_kind;
    logic        e_err, e_bus, resp_seen;
    forever begin
      @(negedge clk);
      if (rst && (exu_rvalid_o || exu_wready_o)) begin
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_done");
        end else begin
          e_val  = exp_q.pop_front();
          e_kind = exp_kind_q.pop_front();
          e_err  = exp_err_q.pop_front();
          e_bus  = exp_bus_q.pop_front();
          resp_seen = e_kind[1] ? r_hs : b_hs;
          check("done_kind", {30'h0, exu_rvalid_o, exu_wready_o}, {30'h0, e_kind});
          check("done_err", {31'h0, exu_err_o}, {31'h0, e_err});
          check("done_rdata", exu_rdata_o, e_val);
          check("done_after_resp", {31'h0, resp_seen}, {31'h0, e_bus});
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_txn(input logic ren, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] size, input int arw, input int rw, input int aww,
                         input int ww, input int bw, input logic [31:0] word,
                         input logic [1:0] rr, input logic [1:0] br);
    int   off, nb, lat;
    logic mis, got, zero_wait;
    off = int'(addr[1:0]);
    nb  = size_bytes(size);
    mis = (off % nb) != 0;
    zero_wait = (arw == 0) && (rw == 0) && (aww == 0) && (ww == 0) && (bw == 0);
    if (ren) begin
      last_load = mis ? 32'h0 : model_load(word, off, size);
      exp_err_q.push_back(mis || (rr != 2'b00));
      exp_kind_q.push_back(2'b10);
    end else begin
      exp_err_q.push_back(mis || (br != 2'b00));
      exp_kind_q.push_back(2'b01);
    end
    exp_q.push_back(last_load);
    exp_bus_q.push_back(!mis);
    ar_wait = arw; r_wait = rw; aw_wait = aww; w_wait = ww; b_wait = bw;
    r_word = word; r_resp_k = rr; b_resp_k = br;
    exp_baddr = addr & 32'hFFFF_FFFC;
    exp_wdata = wd << (8 * off);
    exp_wstrb = 4'(((1 << nb) - 1) << off);
    exp_rd_bus = ren && !mis;
    exp_wr_bus = !ren && !mis;
    exu_ren = ren; exu_wen = !ren; exu_addr = addr; exu_wdata = wd; exu_size = size;
    exu_avalid = 1;
    got = 0; lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exu_rvalid_o || exu_wready_o) begin got = 1; lat = i + 1; break; end
      // request fields changing mid-transaction must have no effect
      exu_addr = $urandom; exu_wdata = $urandom; exu_size = 3'($urandom_range(7));
    end
    if (!got) begin
      flag_fail("done_timeout");
      exp_q.delete(); exp_kind_q.delete(); exp_err_q.delete(); exp_bus_q.delete();
    end else if (zero_wait) begin
      check("latency", lat, mis ? 1 : 3);
    end
    // avalid stays high across the DONE->IDLE edge, then drops
    @(negedge clk);
    exu_avalid = 0;
    exp_rd_bus = 0; exp_wr_bus = 0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valids"}, {24'h0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o,
                             exu_rvalid_o, exu_wready_o, exu_err_o}, 32'h0);
    check({tag, "_araddr"}, araddr_o, 32'h0);
    check({tag, "_awaddr"}, awaddr_o, 32'h0);
    check({tag, "_wdata"}, wdata_o, 32'h0);
    check({tag, "_wstrb"}, {28'h0, wstrb_o}, 32'h0);
    check({tag, "_rdata"}, exu_rdata_o, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] ld_sizes[5];
    logic       ren;
    logic [2:0] sz;
    logic [31:0] a;
    int          nb;
    logic        got;
    ld_sizes[0] = 3'b000; ld_sizes[1] = 3'b001; ld_sizes[2] = 3'b010;
    ld_sizes[3] = 3'b100; ld_sizes[4] = 3'b101;

    rst = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1;
    @(negedge clk);

    // LB sign-extended from the top byte, zero-wait slave
    run_txn(1, 32'h8000_0003, 32'h0, 3'b000, 0, 0, 0, 0, 0, 32'h80FF_1234, 2'b00, 2'b00);
    // LHU with arready delayed 3 cycles
    run_txn(1, 32'h8000_0002, 32'h0, 3'b101, 3, 0, 0, 0, 0, 32'hBEEF_0000, 2'b00, 2'b00);
    // SB: AW accepted 2 cycles before W, then W before AW
    run_txn(0, 32'h8000_0001, 32'h0000_00AB, 3'b000, 0, 0, 0, 2, 1, 32'h0, 2'b00, 2'b00);
    run_txn(0, 32'h8000_0001, 32'h0000_00AB, 3'b000, 0, 0, 2, 0, 0, 32'h0, 2'b00, 2'b00);
    // misaligned SW: no bus activity, error in the next cycle
    run_txn(0, 32'h8000_0002, 32'h1234_5678, 3'b010, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    // LW with SLVERR
    run_txn(1, 32'h8000_0010, 32'h0, 3'b010, 0, 1, 0, 0, 0, 32'hCAFE_F00D, 2'b10, 2'b00);
    // misaligned LH returns zero with error
    run_txn(1, 32'h8000_0005, 32'h0, 3'b001, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    // zero-wait SW with write error
    run_txn(0, 32'h8000_0020, 32'hDEAD_BEEF, 3'b010, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b11);

    // reset while waiting in RD_DATA
    r_wait = 30; ar_wait = 0; r_word = 32'h1111_1111; r_resp_k = 2'b00;
    exp_baddr = 32'h8000_0040;
    exp_rd_bus = 1;
    exu_ren = 1; exu_wen = 0; exu_addr = 32'h8000_0040; exu_size = 3'b010; exu_avalid = 1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rready_o) begin got = 1; break; end
    end
    check("reached_rd_data", {31'h0, got}, 32'h1);
    exu_avalid = 0;
    rst = 0;
    exp_rd_bus = 0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1;
    last_load = 32'h0;
    @(negedge clk);
    run_txn(1, 32'h8000_0044, 32'h0, 3'b010, 0, 0, 0, 0, 0, 32'h5A5A_A5A5, 2'b00, 2'b00);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      ren = 1'($urandom_range(1));
      sz  = ren ? ld_sizes[$urandom_range(4)] : 3'($urandom_range(2));
      nb  = size_bytes(sz);
      a   = $urandom;
      if ($urandom_range(3) != 0) a = a & ~(32'(nb) - 32'd1);
      run_txn(ren, a, $urandom, sz,
              $urandom_range(3), $urandom_range(3), $urandom_range(3),
              $urandom_range(3), $urandom_range(3), $urandom,
              ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    flag_fail("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
